// File: rtl/mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mem_lsu_pkg
// Shared definitions for the load/store unit: data/address width, access
// size encodings, the FSM state enum and small helpers for lane offsets.
//
// Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN (see mem_lsu.sv).
// ---------------------------------------------------------------------------
package mem_lsu_pkg;

    localparam int WIDTH = 32;

    // req_size encodings; 2'b11 is reserved and behaves as a word access
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_DONE
    } lsu_state_e;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        if (size == SZ_BYTE)
            mis = 1'b0;
        else if (size == SZ_HALF)
            mis = off[0];
        else
            mis = (off != 2'b00);
        return mis;
    endfunction

    // Byte offset actually used for the lane: bits that cannot be honoured
    // for the access size are forced to zero.
    function automatic logic [1:0] eff_offset(input logic [1:0] size,
                                              input logic [1:0] off);
        logic [1:0] eff;
        if (size == SZ_BYTE)
            eff = off;
        else if (size == SZ_HALF)
            eff = {off[1], 1'b0};
        else
            eff = 2'b00;
        return eff;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if
// Request/response bundle between the pipeline memory stage (master) and
// the load/store unit (slave).
//
// Signals:
//   req_valid/req_ready  request handshake, transfer on both high at posedge
//   req_we               1 = store, 0 = load
//   req_size             00 byte, 01 half, 10 word, 11 word
//   req_unsigned         zero-extend loads when 1
//   req_addr             byte address
//   req_wdata            store data (low 8/16/32 bits used)
//   resp_valid           one-cycle completion pulse
//   resp_rdata           load result, 0 for stores, held until next response
//   resp_err             misaligned-access flag, valid with resp_valid
// ---------------------------------------------------------------------------
interface mem_lsu_if #(
    parameter int WIDTH = 32
);

    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_lsu_lane.sv
// ---------------------------------------------------------------------------
// mem_lsu_lane
// Purely combinational lane logic for the load/store unit.
//   Load path : pick the addressed byte/half out of the RAM word and sign- or
//               zero-extend it.
//   Store path: merge the new byte/half into the RAM word at the addressed
//               lane (word stores pass the store data through).
// Lanes are little-endian: byte k = bits [8k+7:8k].
//
// Ports:
//   size        access size encoding
//   offset      effective byte offset inside the word
//   is_unsigned zero-extend when 1
//   rdata       current RAM word
//   wdata       store data
//   load_data   extended load result
//   merged      word to write back for a store
// ---------------------------------------------------------------------------
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [1:0]       offset,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] merged
);

    logic [4:0]  bit_base;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign bit_base = {offset, 3'b000};

    // Extract and extend the addressed lane
    always_comb begin
        byte_sel  = rdata[bit_base +: 8];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = is_unsigned ? {16'h0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store data onto the current word
    always_comb begin
        merged = rdata;
        case (size)
            SZ_BYTE: merged[bit_base +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu
// Load/store unit between the pipeline memory stage and a word-organised
// data RAM. Byte/half/word loads and stores on byte addresses become
// word-indexed RAM accesses; sub-word stores are read-modify-write because
// the RAM only has a whole-word write enable.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        request/response bundle (mem_lsu_if.slave)
//   ram_addr   word index (request address >> 2)
//   ram_we     RAM write enable
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, combinational from ram_addr
//
// Optional feature macro MEM_LSU_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses complete without touching the RAM and flag resp_err.
// When undefined, offending low address bits are ignored and resp_err is 0.
// ---------------------------------------------------------------------------
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mem_lsu_if.slave         bus,
    output logic [WIDTH-1:0] ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic             ready;
    logic             accept;
    logic             misalign;
    logic             word_wr;
    logic [1:0]       offset;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged;

    assign offset = eff_offset(size_q, addr_q[1:0]);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(size_q, addr_q[1:0]);
`else
    assign misalign = 1'b0;
`endif

    mem_lsu_lane u_lane (
        .size        (size_q),
        .offset      (offset),
        .is_unsigned (uns_q),
        .rdata       (ram_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept = bus.req_valid && ready;

    // A word store writes straight from the latched data during ACCESS;
    // size 2'b11 counts as a word, hence only size_q[1] is tested.
    assign word_wr = (state_q == ST_ACCESS) && we_q && size_q[1] && !misalign;

    // ram_we is decoded from the registered state so an asynchronous reset
    // drops it immediately.
    assign ram_we    = word_wr || (state_q == ST_WRITE);
    assign ram_wdata = word_wr ? wdata_q : ram_wdata_q;
    assign ram_addr  = {2'b00, addr_q[WIDTH-1:2]};

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_wdata_d  = ram_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                resp_err_d   = misalign;
                resp_rdata_d = '0;
                if (misalign) begin
                    state_d = ST_DONE;
                end else if (!we_q) begin
                    resp_rdata_d = load_data;
                    state_d      = ST_DONE;
                end else if (size_q[1]) begin
                    ram_wdata_d = wdata_q;
                    state_d     = ST_DONE;
                end else begin
                    // merged word is held in ram_wdata_q for the WRITE cycle
                    ram_wdata_d = merged;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase

        // accept is only possible in IDLE/DONE, so it never clashes with
        // the ACCESS updates above
        if (accept) begin
            we_d    = bus.req_we;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            state_d = ST_ACCESS;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu
// Directed self-checking bench for mem_lsu with a 16-word RAM model.
// ---------------------------------------------------------------------------
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [16];

    int vectors     = 0;
    int miscompares = 0;

    mem_lsu_if #(.WIDTH(32)) bus ();

    mem_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[3:0]];

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr[3:0]] <= ram_wdata;
    end

    // Issue one request starting at a negedge while the unit is ready.
    // lat counts negedges after the accepting posedge until resp_valid
    // (2 for load/word store, 3 for sub-word store); -1 on timeout.
    task automatic issue(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err,
                         output int we_cnt, output logic [31:0] waddr);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat    = -1;
        we_cnt = 0;
        rdata  = '0;
        err    = 1'b0;
        waddr  = '0;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                waddr = ram_addr;
            end
            if (bus.resp_valid) begin
                lat   = n;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_resp_valid: got %b expected 0", bus.resp_valid);
        end
        vectors++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_resp: got rdata %h err %b expected 0 0", bus.resp_rdata, bus.resp_err);
        end
        vectors++;
        if (ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_ram: got we %b addr %h wdata %h expected 0 0 0", ram_we, ram_addr, ram_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_word();
        int lat, we_cnt;
        logic [31:0] rd, wa;
        logic er;
        issue(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || we_cnt !== 1 || wa !== 32'h2) begin
            miscompares++;
            $display("[TB] FAIL sw_timing: got lat %0d we %0d addr %h expected 2 1 00000002", lat, we_cnt, wa);
        end
        vectors++;
        if (mem[2] !== 32'hDEADBEEF || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sw_data: got mem %h rdata %h err %b expected deadbeef 0 0", mem[2], rd, er);
        end
        issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || we_cnt !== 0 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lw: got lat %0d we %0d rdata %h err %b expected 2 0 deadbeef 0", lat, we_cnt, rd, er);
        end
    endtask

    task automatic test_subword();
        int lat, we_cnt;
        logic [31:0] rd, wa;
        logic er;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h9, 32'hFFFFFF11, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 3 || we_cnt !== 1 || wa !== 32'h2 || mem[2] !== 32'hDEAD11EF) begin
            miscompares++;
            $display("[TB] FAIL sb: got lat %0d we %0d addr %h mem %h expected 3 1 00000002 dead11ef", lat, we_cnt, wa, mem[2]);
        end
        issue(1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || rd !== 32'h00000011) begin
            miscompares++;
            $display("[TB] FAIL lbu: got lat %0d rdata %h expected 2 00000011", lat, rd);
        end
        issue(1'b0, SZ_BYTE, 1'b0, 32'h8, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (rd !== 32'hFFFFFFEF) begin
            miscompares++;
            $display("[TB] FAIL lb_sign: got %h expected ffffffef", rd);
        end
        issue(1'b1, SZ_HALF, 1'b0, 32'hA, 32'h12348001, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 3 || we_cnt !== 1 || mem[2] !== 32'h800111EF) begin
            miscompares++;
            $display("[TB] FAIL sh: got lat %0d we %0d mem %h expected 3 1 800111ef", lat, we_cnt, mem[2]);
        end
        issue(1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (rd !== 32'hFFFF8001) begin
            miscompares++;
            $display("[TB] FAIL lh: got %h expected ffff8001", rd);
        end
        issue(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (rd !== 32'h00008001) begin
            miscompares++;
            $display("[TB] FAIL lhu: got %h expected 00008001", rd);
        end
        issue(1'b0, SZ_BYTE, 1'b0, 32'hB, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (rd !== 32'hFFFFFF80) begin
            miscompares++;
            $display("[TB] FAIL lb_lane3: got %h expected ffffff80", rd);
        end
        issue(1'b0, SZ_HALF, 1'b1, 32'h8, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (rd !== 32'h000011EF) begin
            miscompares++;
            $display("[TB] FAIL lhu_low: got %h expected 000011ef", rd);
        end
    endtask

    task automatic test_misalign();
        int lat, we_cnt;
        logic [31:0] rd, wa;
        logic er;
        issue(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h12345678, lat, rd, er, we_cnt, wa);
        issue(1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0, lat, rd, er, we_cnt, wa);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        vectors++;
        if (lat !== 2 || er !== 1'b1 || rd !== 32'h0 || we_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL lw_misalign: got lat %0d err %b rdata %h we %0d expected 2 1 0 0", lat, er, rd, we_cnt);
        end
`else
        vectors++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h12345678 || we_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL lw_misalign: got lat %0d err %b rdata %h we %0d expected 2 0 12345678 0", lat, er, rd, we_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        int lat, we_cnt, resp_cnt, late_we;
        logic [31:0] rd, wa;
        logic er;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = SZ_BYTE;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h9;
        bus.req_wdata    = 32'h000000AA;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (ram_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rmw_write_phase: got ram_we %b expected 1", ram_we);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ram_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_we_drop: got ram_we %b expected 0", ram_we);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        resp_cnt = 0;
        late_we  = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_cnt++;
            if (ram_we) late_we++;
        end
        vectors++;
        if (resp_cnt !== 0 || late_we !== 0 || mem[2] !== 32'h800111EF) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got resp %0d we %0d mem %h expected 0 0 800111ef", resp_cnt, late_we, mem[2]);
        end
        issue(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || rd !== 32'h800111EF) begin
            miscompares++;
            $display("[TB] FAIL after_reset_lw: got lat %0d rdata %h expected 2 800111ef", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat, we_cnt;
        logic [31:0] rd, wa;
        logic er;
        issue(1'b1, SZ_WORD, 1'b0, 32'hC, 32'hCAFEF00D, lat, rd, er, we_cnt, wa);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL done_ready: got ready %b valid %b expected 1 1", bus.req_ready, bus.resp_valid);
        end
        issue(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || rd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL b2b_lw: got lat %0d rdata %h expected 2 cafef00d", lat, rd);
        end
        issue(1'b1, SZ_BYTE, 1'b0, 32'hD, 32'h00000077, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 3 || mem[3] !== 32'hCAFE770D || rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL b2b_sb: got lat %0d mem %h rdata %h expected 3 cafe770d 0", lat, mem[3], rd);
        end
        issue(1'b0, SZ_BYTE, 1'b1, 32'hD, 32'h0, lat, rd, er, we_cnt, wa);
        vectors++;
        if (lat !== 2 || rd !== 32'h00000077) begin
            miscompares++;
            $display("[TB] FAIL b2b_lbu: got lat %0d rdata %h expected 2 00000077", lat, rd);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the MIPS pipeline's memory stage and the word-organised data RAM. Accepts byte, halfword and word loads/stores on byte addresses and converts them to word-indexed RAM accesses. Sub-word stores are done as read-modify-write, because the RAM has only a single whole-word write enable. Returns sign- or zero-extended load data with a valid pulse.

## Interface
- WIDTH, 32, data and address width; must be 32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a transfer occurs when req_valid && req_ready on a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; the low 8/16/32 bits are used.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  out  WIDTH  load result; holds its value until the next response; 0 for stores.
- resp_err  out  1  misaligned access flag; valid with resp_valid.
- ram_addr  out  WIDTH  word index (req_addr >> 2, zero-filled).
- ram_we  out  1  RAM write enable.
- ram_wdata  out  WIDTH  RAM write data.
- ram_rdata  in  WIDTH  RAM read data, combinational from ram_addr.

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- req_ready = 1 in IDLE and DONE only.
- On accept, the request is registered (we, size, unsigned, addr, wdata) and the FSM goes to ACCESS.
- ACCESS (ram_addr = latched word index):
  - load: extract the lane from ram_rdata, extend it, register it into resp_rdata, go to DONE.
  - word store: ram_we = 1, ram_wdata = latched wdata, go to DONE.
  - sub-word store: merge the new byte/half into ram_rdata at the addressed lane, register the merged word, go to WRITE.
- WRITE: ram_we = 1, ram_wdata = merged word, same ram_addr, go to DONE.
- DONE: resp_valid = 1.
  - Accept in DONE goes to ACCESS.
  - No accept in DONE goes to IDLE.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], k = addr[1:0].
  - half = bits [15:0] when addr[1] = 0, bits [31:16] when addr[1] = 1.
- ram_we = 0 in IDLE and DONE; ram_addr and ram_wdata hold their last values there.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_addr 0, ram_wdata 0, all latched request fields 0.
- Reset mid-operation: the FSM goes to IDLE immediately and ram_we drops asynchronously. No partial write is issued after reset releases, and no response is produced for the aborted request.

## Timing
- Accept on edge T:
  - load or word store: resp_valid in cycle T+2.
  - sub-word store: resp_valid in cycle T+3.
- The RAM write commits at the edge ending the ACCESS cycle (word store) or the WRITE cycle (sub-word store).
- A load accepted in DONE, directly after a store, reads the updated word.
- Maximum throughput: one load or word store every 2 cycles, one sub-word store every 3 cycles.
- req_valid may drop at any time without having been accepted; inputs are sampled only on accept.

## Configuration
- MEM_LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, goes from ACCESS straight to DONE.
  - No RAM write occurs; resp_err = 1 and resp_rdata = 0.
- MEM_LSU_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored (forced to 0); resp_err is constant 0.

## Structure
- Package mem_lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
- One sub-module, mem_lsu_lane: purely combinational extract/extend (load path) and merge (store path), driven by size, addr[1:0] and unsigned.
- The FSM and registers stay in mem_lsu.

## Test plan
- sw 0xDEADBEEF to addr 0x8, then lw 0x8 -> ram_addr 2, ram_we for one cycle; resp_rdata 0xDEADBEEF at T+2; resp_err 0.
- After the above, sb 0x11 to addr 0x9 -> read-modify-write; RAM word 2 becomes 0xDEAD11EF; resp_valid at T+3; lbu 0x9 -> 0x00000011.
- sh 0x8001 to addr 0xA, then lh 0xA -> 0xFFFF8001 and lhu 0xA -> 0x00008001; RAM word 2 = 0x800111EF.
- lw 0x6 with the macro -> resp_err 1, resp_rdata 0, no ram_we. Without the macro -> reads word 1, resp_err 0.
- rst low during the WRITE state of an sb -> ram_we falls immediately; no resp_valid after release; the next request completes normally.
- Back-to-back requests: a load accepted in the DONE cycle of an sw -> the load response arrives 2 cycles later and returns the newly stored word.
